// File: rtl/rf_sched_pkg.sv
// ----------------------------------------------------------------------------
// rf_sched_pkg
// Shared definitions for the register-file write scheduler: default sizes,
// the scheduler state encoding and the index of the hard-wired zero register.
// ----------------------------------------------------------------------------
package rf_sched_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Register x0 always reads as zero; writes to it are swallowed.
    localparam int X0_IDX = 0;

    typedef enum logic {
        INIT,   // zero-fill sweep owns the write port
        RUN     // core / accelerator arbitration
    } sched_state_t;

endpackage

// File: rtl/rf_clear_sequencer.sv
// ----------------------------------------------------------------------------
// rf_clear_sequencer
// Walks an index from 0 to NUM_REGS-1, one step per enabled cycle, so the
// parent can write zero into every register after reset.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low
//   i_en       in   sweep may advance this cycle
//   o_wr_en    out  a clear write is presented this cycle
//   o_wr_addr  out  register index being cleared
//   o_done     out  high while enabled after the last index was issued
// ----------------------------------------------------------------------------
module rf_clear_sequencer
    import rf_sched_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_done
);

    logic [ADDR_W-1:0] r_idx;
    logic              r_swept;
    logic              w_last;

    assign w_last = (r_idx == ADDR_W'(NUM_REGS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idx   <= '0;
            r_swept <= 1'b0;
        end else if (i_en && !r_swept) begin
            if (w_last) begin
                r_swept <= 1'b1;
            end else begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

    assign o_wr_en   = i_en && !r_swept;
    assign o_wr_addr = r_idx;
    // Falls as soon as the parent leaves INIT and drops i_en.
    assign o_done    = i_en && r_swept;

endmodule

// File: rtl/rf_write_scheduler.sv
// ----------------------------------------------------------------------------
// rf_write_scheduler
// Owns the single write port of the register file. After reset it clears
// every register with a zero-fill sweep, then arbitrates between the core
// writeback stage and the kNN accelerator result writer. The core has
// priority, but an accelerator denied STARVE_MAX cycles in a row is forced
// to win the next one. The register-file write signals are registered.
//
// Ports:
//   clock, reset                        clock; synchronous active-low reset
//   core_wr_valid/addr/data, _ready     core writeback request + accept
//   acc_wr_valid/addr/data, _ready      accelerator request + accept
//   rf_regwrite/rf_write_reg/_data      registered register-file write port
//   init_done                           high once the clear sweep finished
// ----------------------------------------------------------------------------
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_wr_valid,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic              core_wr_ready,
    input  logic              acc_wr_valid,
    input  logic [ADDR_W-1:0] acc_wr_addr,
    input  logic [DATA_W-1:0] acc_wr_data,
    output logic              acc_wr_ready,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              init_done
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    sched_state_t      r_state, w_state_next;
    logic [CNT_W-1:0]  r_starve, w_starve_next;
    logic              r_regwrite, w_we_next;
    logic [ADDR_W-1:0] r_write_reg, w_reg_next;
    logic [DATA_W-1:0] r_write_data, w_data_next;

    logic              w_seq_en;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_seq_done;
    logic              w_run;
    logic              w_force;
    logic              w_core_hs;
    logic              w_acc_hs;

    rf_clear_sequencer #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .i_en      (r_state == INIT),
        .o_wr_en   (w_seq_en),
        .o_wr_addr (w_seq_addr),
        .o_done    (w_seq_done)
    );

    // Readies depend only on core_wr_valid and registered state, so no
    // combinational loop can form through a requester.
    assign w_run         = (r_state == RUN);
    assign w_force       = (r_starve == CNT_W'(STARVE_MAX));
    assign core_wr_ready = w_run && !w_force;
    assign acc_wr_ready  = w_run && (w_force || !core_wr_valid);
    // The ready terms are mutually exclusive whenever the core is valid,
    // so at most one of these can be true.
    assign w_core_hs     = core_wr_valid && core_wr_ready;
    assign w_acc_hs      = acc_wr_valid && acc_wr_ready;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // which keeps synthesis from inferring latches on unassigned paths.
        w_state_next  = r_state;
        w_starve_next = r_starve;
        w_we_next     = 1'b0;
        w_reg_next    = r_write_reg;
        w_data_next   = r_write_data;

        case (r_state)
            INIT: begin
                w_starve_next = '0;
                if (w_seq_en) begin
                    w_we_next   = 1'b1;
                    w_reg_next  = w_seq_addr;
                    w_data_next = '0;
                end
                if (w_seq_done) begin
                    w_state_next = RUN;
                end
            end

            RUN: begin
                // A write to x0 completes its handshake but never asserts
                // the enable, so x0 stays zero.
                if (w_core_hs) begin
                    w_we_next   = (core_wr_addr != ADDR_W'(X0_IDX));
                    w_reg_next  = core_wr_addr;
                    w_data_next = core_wr_data;
                end else if (w_acc_hs) begin
                    w_we_next   = (acc_wr_addr != ADDR_W'(X0_IDX));
                    w_reg_next  = acc_wr_addr;
                    w_data_next = acc_wr_data;
                end

                if (!acc_wr_valid || w_acc_hs) begin
                    w_starve_next = '0;
                end else if (!w_force) begin
                    w_starve_next = r_starve + CNT_W'(1);
                end
            end

            default: w_state_next = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= INIT;
            r_starve     <= '0;
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve     <= w_starve_next;
            r_regwrite   <= w_we_next;
            r_write_reg  <= w_reg_next;
            r_write_data <= w_data_next;
        end
    end

    assign rf_regwrite   = r_regwrite;
    assign rf_write_reg  = r_write_reg;
    assign rf_write_data = r_write_data;
    assign init_done     = w_run;

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Sequencer and arbiter for the single write port of the 32×32 register file. After reset it sweeps zeros into every register, one per cycle, so the register file needs no reset loop of its own. It then shares the write port between the core writeback stage and the kNN accelerator result writer. It drives the register file's `regwrite`/`write_reg`/`write_data` inputs from registered outputs.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width
- `NUM_REGS`, 32, registers cleared by the init sweep
- `STARVE_MAX`, 4, consecutive denied accelerator cycles before the accelerator is forced to win

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `core_wr_valid`  in  1  core writeback request
- `core_wr_addr`  in  ADDR_W  core destination register
- `core_wr_data`  in  DATA_W  core write data
- `core_wr_ready`  out  1  core request accepted this cycle when valid&ready
- `acc_wr_valid`  in  1  accelerator write request
- `acc_wr_addr`  in  ADDR_W  accelerator destination register
- `acc_wr_data`  in  DATA_W  accelerator write data
- `acc_wr_ready`  out  1  accelerator request accepted when valid&ready
- `rf_regwrite`  out  1  register file write enable (registered)
- `rf_write_reg`  out  ADDR_W  register file write index (registered)
- `rf_write_data`  out  DATA_W  register file write data (registered)
- `init_done`  out  1  high once the clear sweep is complete

## Operation
- States:
  - INIT: clear sweep, index `idx` counts 0..NUM_REGS-1.
  - RUN: arbitration.
- INIT:
  - Each cycle, present a write of 0 to register `idx`, then increment `idx`.
  - After index NUM_REGS-1, go to RUN.
  - Both readies are 0 throughout INIT.
- RUN grant:
  - `force = (starve_cnt == STARVE_MAX)`.
  - `core_wr_ready = !force`.
  - `acc_wr_ready = force || !core_wr_valid`.
  - At most one handshake completes per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when `acc_wr_valid && !acc_wr_ready`.
  - Clears when the accelerator handshake completes or `acc_wr_valid` is 0.
- Accepted write, cycle after the handshake: `rf_regwrite=1`, `rf_write_reg`/`rf_write_data` = winner's addr/data.
- Write to register 0 (from either requester):
  - The handshake completes normally.
  - `rf_regwrite` stays 0, so x0 remains zero.
- No handshake: `rf_regwrite=0`; `rf_write_reg`/`rf_write_data` hold their previous values.
- Requesters hold addr/data stable while valid and not ready.

## Timing
- Reset (`reset==0` at an edge, including mid-sweep or mid-RUN):
  - state INIT, idx 0, starve_cnt 0.
  - `rf_regwrite` 0, `rf_write_reg` 0, `rf_write_data` 0, `init_done` 0.
  - Any in-flight request is dropped.
- Let E0 be the first edge with `reset==1`.
  - After edge Ek (k = 0..NUM_REGS-1): `rf_regwrite=1`, `rf_write_reg=k`, `rf_write_data=0`.
  - After E(NUM_REGS): `rf_regwrite=0` and `init_done=1`. Readies may assert in this same cycle.
  - Total: NUM_REGS+1 cycles from reset release to first accept.
- Write latency: a handshake at edge N gives `rf_regwrite` high in the cycle following edge N.
  - So data is in the register file at edge N+1.
  - Back-to-back writes sustain one per cycle.
- Readies are combinational from `core_wr_valid` and registered `starve_cnt`. There is no path from ready back to valid.
- Simultaneous valid from both requesters:
  - Core wins unless `force`.
  - With continuous contention, the accelerator wins on the STARVE_MAX+1-th cycle it is pending.
- `init_done` stays 1 until the next reset.

## Structure
- Package `rf_sched_pkg` holds:
  - the state enum `{INIT, RUN}`;
  - `DATA_W`/`ADDR_W`/`NUM_REGS`/`STARVE_MAX` defaults;
  - the `x0` index constant shared with the register file and decoder.
- One sub-module, `rf_clear_sequencer`: owns `idx`, emits the sweep address and enable, and raises a done pulse.
- Arbitration, the starvation counter and the output registers stay in the top.

## Test plan
- Reset release, no requests:
  - Outputs write reg 0..31 with data 0 on 32 consecutive cycles.
  - `init_done` rises on the 33rd cycle.
  - Readies are 0 before that cycle.
- After init, core writes addr 5, data 0xDEADBEEF alone:
  - Next cycle shows `rf_regwrite=1`, `rf_write_reg=5`, `rf_write_data=0xDEADBEEF`.
  - The cycle after that shows `rf_regwrite=0`.
- Core and accelerator both valid continuously (core addr 3, acc addr 7):
  - Core is granted 4 cycles, accelerator on the 5th, then core 4 more cycles.
  - The pattern repeats; no lost or duplicated write.
- Accelerator writes addr 0, data 0x1234: the handshake completes, `rf_regwrite` stays 0.
- `reset=0` asserted mid-sweep at idx 17 and held one cycle: outputs are 0; on release the sweep restarts at reg 0.
- `reset=0` asserted with an accelerator request pending and starve_cnt=3: starve_cnt returns to 0 and the full init sweep is repeated before any grant.
